// File: rtl/pll_lock_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer_pkg
// Purpose  : Shared state encodings and elaboration helpers for the PLL lock
//            sequencer.
// Revision : 1.0  initial release
// ============================================================================
package pll_lock_sequencer_pkg;

   // Encodings are visible on the STATE status port, so they are fixed values.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLL_RESET = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   // Ceiling log2, used to size the shared timer at elaboration.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer_if
// Purpose  : Control, PLL pin and status bundle of the PLL lock sequencer.
//            master = slow-control / board side, slave = sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pll_lock_sequencer_if #(
   parameter int LOSS_W = 8
);
   logic              enable;
   logic              relock_req;
   logic              pll_locked;
   logic              pll_rst;
   logic              domain_rst;
   logic              ready;
   logic              fail;
   logic [3:0]        retry_cnt;
   logic [LOSS_W-1:0] loss_cnt;
   logic [2:0]        state;

   modport master (
      output enable, relock_req, pll_locked,
      input  pll_rst, domain_rst, ready, fail, retry_cnt, loss_cnt, state
   );

   modport slave (
      input  enable, relock_req, pll_locked,
      output pll_rst, domain_rst, ready, fail, retry_cnt, loss_cnt, state
   );
endinterface
`default_nettype wire

// File: rtl/pll_lock_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous level, with
//            asynchronous active-high reset to 0.
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic d,
   output logic      q
);
   logic meta;

   // Two back-to-back flops; the first may go metastable, the second settles it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Resets the board PLL, qualifies LOCKED (sync, timeout, stability
//            window), retries failed locks and releases the master reset of
//            the PLL-derived clock domains. Runs on the reference clock.
// Revision : 1.0  initial release
// ============================================================================
module pll_lock_sequencer
   import pll_lock_sequencer_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 4096,
   parameter int MAX_RETRIES   = 4,
   parameter int LOSS_W        = 8
) (
   input wire logic             clk,
   input wire logic             rst,
   pll_lock_sequencer_if.slave  bus
);
   localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_T  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int TW     = clog2(MAX_T) + 1;

   state_t            state, state_nx;
   logic [TW-1:0]     timer;
   logic              timer_clr;
   logic [3:0]        retry_cnt, retry_nx, retry_inc;
   logic [LOSS_W-1:0] loss_cnt, loss_nx;
   logic              lk;
   logic              pll_rst, domain_rst, ready, fail;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.pll_locked),
      .q   (lk)
   );

   assign retry_inc = retry_cnt + 4'd1;

   // Next-state, timer restart and counter updates; ENABLE=0 overrides everything.
   always_comb begin
      state_nx  = state;
      timer_clr = 1'b0;
      retry_nx  = retry_cnt;
      loss_nx   = loss_cnt;
      if (!bus.enable) begin
         state_nx = ST_IDLE;
         retry_nx = 4'd0;
      end else begin
         case (state)
            ST_IDLE: state_nx = ST_PLL_RESET;
            ST_PLL_RESET: begin
               if (bus.relock_req) begin
                  timer_clr = 1'b1;
                  retry_nx  = 4'd0;
               end else if (timer == TW'(RST_CYCLES - 1)) begin
                  state_nx = ST_WAIT_LOCK;
               end
            end
            ST_WAIT_LOCK: begin
               if (bus.relock_req) begin
                  state_nx = ST_PLL_RESET;
                  retry_nx = 4'd0;
               end else if (lk) begin
                  state_nx = ST_STABLE;
               end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                  retry_nx = retry_inc;
                  state_nx = (retry_inc == 4'(MAX_RETRIES)) ? ST_FAIL : ST_PLL_RESET;
               end
            end
            ST_STABLE: begin
               if (bus.relock_req) begin
                  state_nx = ST_PLL_RESET;
                  retry_nx = 4'd0;
               end else if (!lk) begin
                  // Short dropout: requalify without touching the PLL.
                  state_nx = ST_WAIT_LOCK;
               end else if (timer == TW'(STABLE_CYCLES)) begin
                  // RUN is taken on the edge after STABLE_CYCLES locked
                  // cycles have been fully spent in STABLE.
                  state_nx = ST_RUN;
                  retry_nx = 4'd0;
               end
            end
            ST_RUN: begin
               if (!lk) begin
                  state_nx = ST_PLL_RESET;
                  if (loss_cnt != '1) loss_nx = loss_cnt + LOSS_W'(1);
               end else if (bus.relock_req) begin
                  state_nx = ST_PLL_RESET;
               end
            end
            ST_FAIL: begin
               if (bus.relock_req) begin
                  state_nx = ST_PLL_RESET;
                  retry_nx = 4'd0;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
      if (state_nx != state) timer_clr = 1'b1;
   end

   // State, timer, counters and registered outputs derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         timer      <= '0;
         retry_cnt  <= 4'd0;
         loss_cnt   <= '0;
         pll_rst    <= 1'b1;
         domain_rst <= 1'b1;
         ready      <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state     <= state_nx;
         retry_cnt <= retry_nx;
         loss_cnt  <= loss_nx;
         if (timer_clr)        timer <= '0;
         else if (timer != '1) timer <= timer + TW'(1);
         pll_rst    <= (state_nx == ST_IDLE) || (state_nx == ST_PLL_RESET) ||
                       (state_nx == ST_FAIL);
         domain_rst <= (state_nx != ST_RUN);
         ready      <= (state_nx == ST_RUN);
         fail       <= (state_nx == ST_FAIL);
      end
   end

   assign bus.pll_rst    = pll_rst;
   assign bus.domain_rst = domain_rst;
   assign bus.ready      = ready;
   assign bus.fail       = fail;
   assign bus.retry_cnt  = retry_cnt;
   assign bus.loss_cnt   = loss_cnt;
   assign bus.state      = state;
endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Purpose  : Directed self-checking bench for pll_lock_sequencer
//            (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_pll_lock_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   pll_lock_sequencer_if #(.LOSS_W(8)) pif ();

   pll_lock_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (32),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (3),
      .LOSS_W        (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (pif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pif.enable = 1'b0;
      pif.relock_req = 1'b0;
      pif.pll_locked = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Cycles pll_rst keeps value v, starting from the current sample.
   task automatic run_len(input logic v, output int n);
      n = 0;
      while (pif.pll_rst === v && n < 300) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_state(input logic [2:0] s, output int n);
      n = 0;
      while (pif.state !== s && n < 300) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pif.enable = 1'b1;
      pif.relock_req = 1'b0;
      pif.pll_locked = 1'b1;
      tick();
      tick();
      tests_run++; if (pif.state !== 3'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", pif.state); end
      tests_run++; if (pif.pll_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_pll_rst got %b want 1", pif.pll_rst); end
      tests_run++; if (pif.domain_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_domain_rst got %b want 1", pif.domain_rst); end
      tests_run++; if (pif.ready !== 1'b0 || pif.fail !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_fail got %b%b want 00", pif.ready, pif.fail); end
      tests_run++; if (pif.retry_cnt !== 4'd0 || pif.loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_counters got %0d/%0d want 0/0", pif.retry_cnt, pif.loss_cnt); end
   endtask

   task automatic test_nominal();
      int n;
      do_reset();
      pif.enable = 1'b1;
      tick();
      tests_run++; if (pif.state !== 3'd1) begin tests_failed++; $display("FAIL nom_enter_reset got %0d want 1", pif.state); end
      run_len(1'b1, n);
      tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL nom_pll_rst_len got %0d want 4", n); end
      repeat (10) tick();
      pif.pll_locked = 1'b1;
      wait_state(3'd4, n);
      tests_run++; if (n !== 12) begin tests_failed++; $display("FAIL nom_lock_to_run got %0d want 12", n); end
      tests_run++; if (pif.ready !== 1'b1 || pif.domain_rst !== 1'b0) begin tests_failed++; $display("FAIL nom_run_outputs got ready=%b drst=%b want 1/0", pif.ready, pif.domain_rst); end
      tests_run++; if (pif.retry_cnt !== 4'd0) begin tests_failed++; $display("FAIL nom_retry got %0d want 0", pif.retry_cnt); end
   endtask

   task automatic test_timeout_fail();
      int n;
      do_reset();
      pif.enable = 1'b1;
      tick();
      run_len(1'b1, n);
      tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL to_first_pulse got %0d want 4", n); end
      for (int i = 0; i < 3; i++) begin
         run_len(1'b0, n);
         tests_run++; if (n !== 32) begin tests_failed++; $display("FAIL to_wait_len[%0d] got %0d want 32", i, n); end
         tests_run++; if (pif.retry_cnt !== 4'(i + 1)) begin tests_failed++; $display("FAIL to_retry[%0d] got %0d want %0d", i, pif.retry_cnt, i + 1); end
         if (i < 2) begin
            run_len(1'b1, n);
            tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL to_pulse[%0d] got %0d want 4", i, n); end
         end else begin
            tests_run++; if (pif.state !== 3'd5 || pif.fail !== 1'b1 || pif.pll_rst !== 1'b1) begin tests_failed++; $display("FAIL to_fail_entry got st=%0d fail=%b prst=%b want 5/1/1", pif.state, pif.fail, pif.pll_rst); end
         end
      end
      repeat (5) tick();
      tests_run++; if (pif.state !== 3'd5) begin tests_failed++; $display("FAIL to_fail_hold got %0d want 5", pif.state); end
      pif.relock_req = 1'b1;
      tick();
      pif.relock_req = 1'b0;
      tests_run++; if (pif.retry_cnt !== 4'd0 || pif.state !== 3'd1 || pif.fail !== 1'b0) begin tests_failed++; $display("FAIL to_relock got retry=%0d st=%0d fail=%b want 0/1/0", pif.retry_cnt, pif.state, pif.fail); end
      run_len(1'b1, n);
      tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL to_relock_pulse got %0d want 4", n); end
   endtask

   task automatic test_glitch();
      int n;
      logic saw_wait, saw_rst;
      do_reset();
      pif.pll_locked = 1'b1;
      pif.enable = 1'b1;
      wait_state(3'd3, n);
      tests_run++; if (n !== 6) begin tests_failed++; $display("FAIL gl_reach_stable got %0d want 6", n); end
      repeat (5) tick();
      pif.pll_locked = 1'b0;
      tick();
      pif.pll_locked = 1'b1;
      n = 0; saw_wait = 1'b0; saw_rst = 1'b0;
      while (pif.state !== 3'd4 && n < 300) begin
         tick();
         n++;
         if (pif.state === 3'd2) saw_wait = 1'b1;
         if (pif.pll_rst !== 1'b0) saw_rst = 1'b1;
      end
      tests_run++; if (saw_wait !== 1'b1) begin tests_failed++; $display("FAIL gl_back_to_wait got %b want 1", saw_wait); end
      tests_run++; if (saw_rst !== 1'b0) begin tests_failed++; $display("FAIL gl_no_pll_rst got %b want 0", saw_rst); end
      tests_run++; if (n !== 12) begin tests_failed++; $display("FAIL gl_restore_to_run got %0d want 12", n); end
      tests_run++; if (pif.retry_cnt !== 4'd0) begin tests_failed++; $display("FAIL gl_retry got %0d want 0", pif.retry_cnt); end
   endtask

   task automatic test_lock_loss();
      int n, stalls;
      pif.pll_locked = 1'b0;
      n = 0;
      while (pif.domain_rst !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL ll_drst_delay got %0d want 3", n); end
      tests_run++; if (pif.ready !== 1'b0 || pif.state !== 3'd1) begin tests_failed++; $display("FAIL ll_outputs got ready=%b st=%0d want 0/1", pif.ready, pif.state); end
      tests_run++; if (pif.loss_cnt !== 8'd1) begin tests_failed++; $display("FAIL ll_loss_cnt got %0d want 1", pif.loss_cnt); end
      run_len(1'b1, n);
      tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL ll_pulse got %0d want 4", n); end
      stalls = 0;
      for (int k = 0; k < 255; k++) begin
         pif.pll_locked = 1'b1;
         wait_state(3'd4, n);
         if (n >= 300) stalls++;
         pif.pll_locked = 1'b0;
         wait_state(3'd1, n);
         if (n >= 300) stalls++;
         if (k == 253) begin
            tests_run++; if (pif.loss_cnt !== 8'd255) begin tests_failed++; $display("FAIL ll_reach_255 got %0d want 255", pif.loss_cnt); end
         end
      end
      tests_run++; if (stalls !== 0) begin tests_failed++; $display("FAIL ll_loop_timeouts got %0d want 0", stalls); end
      tests_run++; if (pif.loss_cnt !== 8'd255) begin tests_failed++; $display("FAIL ll_saturate got %0d want 255", pif.loss_cnt); end
   endtask

   task automatic test_simultaneous();
      int n;
      do_reset();
      pif.pll_locked = 1'b1;
      pif.enable = 1'b1;
      wait_state(3'd4, n);
      pif.relock_req = 1'b1;
      tick();
      pif.relock_req = 1'b0;
      tests_run++; if (pif.state !== 3'd1 || pif.domain_rst !== 1'b1 || pif.loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL sim_relock_only got st=%0d drst=%b loss=%0d want 1/1/0", pif.state, pif.domain_rst, pif.loss_cnt); end
      wait_state(3'd4, n);
      pif.pll_locked = 1'b0;
      tick();
      tick();
      pif.relock_req = 1'b1;
      tick();
      pif.relock_req = 1'b0;
      tests_run++; if (pif.loss_cnt !== 8'd1 || pif.state !== 3'd1) begin tests_failed++; $display("FAIL sim_loss_and_relock got loss=%0d st=%0d want 1/1", pif.loss_cnt, pif.state); end
      pif.pll_locked = 1'b1;
      wait_state(3'd4, n);
      pif.enable = 1'b0;
      pif.relock_req = 1'b1;
      tick();
      pif.relock_req = 1'b0;
      tests_run++; if (pif.state !== 3'd0 || pif.pll_rst !== 1'b1 || pif.domain_rst !== 1'b1 || pif.ready !== 1'b0) begin tests_failed++; $display("FAIL sim_disable_relock got st=%0d prst=%b drst=%b rdy=%b want 0/1/1/0", pif.state, pif.pll_rst, pif.domain_rst, pif.ready); end
   endtask

   task automatic test_async_reset();
      int n;
      pif.pll_locked = 1'b0;
      pif.enable = 1'b1;
      n = 0;
      while (!(pif.retry_cnt === 4'd1 && pif.state === 3'd2) && n < 300) begin tick(); n++; end
      tests_run++; if (pif.retry_cnt !== 4'd1 || pif.state !== 3'd2) begin tests_failed++; $display("FAIL ar_reach_retry1 got retry=%0d st=%0d want 1/2", pif.retry_cnt, pif.state); end
      pif.relock_req = 1'b1;
      tick();
      pif.relock_req = 1'b0;
      tests_run++; if (pif.retry_cnt !== 4'd0 || pif.state !== 3'd1) begin tests_failed++; $display("FAIL ar_relock_wait got retry=%0d st=%0d want 0/1", pif.retry_cnt, pif.state); end
      n = 0;
      while (!(pif.retry_cnt === 4'd1 && pif.state === 3'd2) && n < 300) begin tick(); n++; end
      repeat (3) tick();
      #3;
      rst = 1'b1;
      #1;
      tests_run++; if (pif.state !== 3'd0 || pif.pll_rst !== 1'b1) begin tests_failed++; $display("FAIL ar_immediate got st=%0d prst=%b want 0/1", pif.state, pif.pll_rst); end
      tests_run++; if (pif.retry_cnt !== 4'd0 || pif.loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL ar_counters got %0d/%0d want 0/0", pif.retry_cnt, pif.loss_cnt); end
      tests_run++; if (pif.domain_rst !== 1'b1 || pif.ready !== 1'b0 || pif.fail !== 1'b0) begin tests_failed++; $display("FAIL ar_outputs got drst=%b rdy=%b fail=%b want 1/0/0", pif.domain_rst, pif.ready, pif.fail); end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_timeout_fail();
      test_glitch();
      test_lock_loss();
      test_simultaneous();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
